// File: rtl/quan_mult_e_sched_if.sv
// Bus bundle for quan_mult_e_sched: job command, E-set fetch, sum-vector stream and result tags.
// master = the sequencer, slave = the surrounding datapath / environment.
interface quan_mult_e_sched_if #(
  parameter int CNT_WIDTH   = 16,
  parameter int E_SET_WIDTH = 32
);
  logic                   start;
  logic [3:0]             mode_cfg;
  logic [CNT_WIDTH-1:0]   vec_num;
  logic                   e_req;
  logic                   e_ack;
  logic [E_SET_WIDTH-1:0] e_set_in;
  logic                   sum_valid;
  logic                   sum_ready;
  logic                   vec_en;
  logic [3:0]             vec_mode;
  logic [E_SET_WIDTH-1:0] vec_e_set;
  logic                   credit_ret;
  logic                   res_valid;
  logic                   res_last;

  modport master (
    input  start, mode_cfg, vec_num, e_ack, e_set_in, sum_valid, credit_ret,
    output e_req, sum_ready, vec_en, vec_mode, vec_e_set, res_valid, res_last
  );

  modport slave (
    output start, mode_cfg, vec_num, e_ack, e_set_in, sum_valid, credit_ret,
    input  e_req, sum_ready, vec_en, vec_mode, vec_e_set, res_valid, res_last
  );
endinterface

// File: rtl/quan_mult_e_sched.sv
// Sequencer for the quantization sum x E multiplier stage: E-set fetch, credit-metered vector issue,
// and valid/last tag tracking through the external mult pipeline. Optional stall counter: QUAN_SCHED_STALL_CNT_EN.
//
// state    | meaning
// S_IDLE   | waiting for a legal start
// S_LOAD_E | e_req high until e_ack delivers the E set
// S_RUN    | issuing sum vectors under credit control
// S_DRAIN  | waiting for in-flight products to leave, then done
module quan_mult_e_sched #(
  parameter int MULT_LAT    = 3,
  parameter int CNT_WIDTH   = 16,
  parameter int CREDIT_MAX  = 8,
  parameter int E_SET_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  quan_mult_e_sched_if.master         bus,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err,
  output logic                        credit_ovf,
  output logic [31:0]                 stall_cnt
);

  localparam int CRW = $clog2(CREDIT_MAX + 1);
  localparam logic [CRW-1:0]       CREDIT_FULL = CRW'(CREDIT_MAX);
  localparam logic [CRW-1:0]       CR_ONE      = CRW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_E, S_RUN, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             mode_q;
  logic [CNT_WIDTH-1:0]   num_q;
  logic [CNT_WIDTH-1:0]   issued_q;
  logic [CRW-1:0]         credit_q;
  logic [MULT_LAT:0]      pipe_v_q;
  logic [MULT_LAT:0]      pipe_l_q;
  logic [3:0]             vec_mode_q;
  logic [E_SET_WIDTH-1:0] vec_e_set_q;
  logic                   e_req_c;
  logic                   ready_c;
  logic                   done_d;
  logic                   xfer;
  logic                   last_vec;
  logic                   mode_ok;
  logic                   start_ok;
  logic                   pipe_busy;

  assign mode_ok   = (bus.mode_cfg <= 4'd1);
  assign start_ok  = (state_q == S_IDLE) && bus.start && mode_ok;
  assign last_vec  = (issued_q == (num_q - CNT_ONE));
  assign xfer      = bus.sum_valid && ready_c;
  // The output stage holds the final tag in its last cycle; done registers off the earlier stages.
  assign pipe_busy = |pipe_v_q[MULT_LAT-1:0];

  always_comb begin
    state_d = state_q;
    e_req_c = 1'b0;
    ready_c = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_LOAD_E;
      end
      S_LOAD_E: begin
        e_req_c = 1'b1;
        if (bus.e_ack) state_d = (num_q == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        ready_c = (credit_q != '0) && (issued_q < num_q);
        if (bus.sum_valid && ready_c && last_vec) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pipe_busy) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      credit_q    <= CREDIT_FULL;
      credit_ovf  <= 1'b0;
      pipe_v_q    <= '0;
      pipe_l_q    <= '0;
      vec_mode_q  <= '0;
      vec_e_set_q <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q  <= state_d;
      done     <= done_d;
      cfg_err  <= (state_q == S_IDLE) && bus.start && !mode_ok;
      pipe_v_q <= {pipe_v_q[MULT_LAT-1:0], xfer};
      pipe_l_q <= {pipe_l_q[MULT_LAT-1:0], xfer && last_vec};

      if (start_ok) begin
        mode_q   <= bus.mode_cfg;
        num_q    <= bus.vec_num;
        issued_q <= '0;
      end else if (xfer) begin
        issued_q <= issued_q + CNT_ONE;
      end

      if ((state_q == S_LOAD_E) && bus.e_ack) begin
        vec_mode_q  <= mode_q;
        vec_e_set_q <= bus.e_set_in;
      end

      case ({xfer, bus.credit_ret})
        2'b10: credit_q <= credit_q - CR_ONE;
        2'b01: begin
          if (credit_q == CREDIT_FULL) credit_ovf <= 1'b1;
          else                         credit_q   <= credit_q + CR_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef QUAN_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && bus.sum_valid && (credit_q == '0) &&
                 (issued_q < num_q) && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign bus.e_req     = e_req_c;
  assign bus.sum_ready = ready_c;
  assign bus.vec_en    = xfer;
  assign bus.vec_mode  = vec_mode_q;
  assign bus.vec_e_set = vec_e_set_q;
  assign bus.res_valid = pipe_v_q[MULT_LAT];
  assign bus.res_last  = pipe_l_q[MULT_LAT];
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_quan_mult_e_sched.sv
// Randomized bench for quan_mult_e_sched against a cycle-stamped job/credit model.
// Build with QUAN_SCHED_STALL_CNT_EN defined to also check the stall counter.
module tb_quan_mult_e_sched;
  localparam int ML   = 3;
  localparam int CMAX = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, done, cfg_err, credit_ovf;
  logic [31:0] stall_cnt;

  quan_mult_e_sched_if #(.CNT_WIDTH(16), .E_SET_WIDTH(32)) bus ();

  quan_mult_e_sched #(
    .MULT_LAT(ML), .CNT_WIDTH(16), .CREDIT_MAX(CMAX), .E_SET_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done),
    .cfg_err(cfg_err), .credit_ovf(credit_ovf), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Model: one job described by timestamps, plus credit pool and expected product queue.
  bit          m_job;
  int          m_start_cyc, m_ack_cyc, m_done_cyc, m_cfg_cyc;
  int          m_num, m_issued, m_credits;
  bit          m_ovf;
  longint      m_stall;
  logic [31:0] m_eset;
  logic [3:0]  m_mode, m_mode_pend;
  int          res_cyc_q[$];
  bit          res_last_q[$];
  bit          last_xfer;
  int          obs_en, obs_res;

  bit e_req_x, ready_x, xfer_x, rv_x, rl_x, busy_x, lastv;

  task automatic model_reset();
    m_job = 0; m_start_cyc = -1; m_ack_cyc = -1; m_done_cyc = -1; m_cfg_cyc = -1;
    m_num = 0; m_issued = 0; m_credits = CMAX; m_ovf = 0; m_stall = 0;
    m_eset = '0; m_mode = '0; m_mode_pend = '0;
    res_cyc_q.delete(); res_last_q.delete();
    last_xfer = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      check_val("rst_busy", busy, 0);
      check_val("rst_res_valid", bus.res_valid, 0);
      check_val("rst_ovf", credit_ovf, 0);
      check_val("rst_eset", bus.vec_e_set, 0);
    end else begin
      e_req_x = m_job && (m_ack_cyc < 0) && (cyc > m_start_cyc);
      ready_x = m_job && (m_ack_cyc >= 0) && (cyc > m_ack_cyc) && (m_issued < m_num) && (m_credits > 0);
      xfer_x  = ready_x && bus.sum_valid;
      rv_x    = (res_cyc_q.size() > 0) && (res_cyc_q[0] == cyc);
      rl_x    = rv_x && res_last_q[0];
      busy_x  = m_job && (cyc > m_start_cyc) && (cyc != m_done_cyc);
      if (bus.vec_en)    obs_en++;
      if (bus.res_valid) obs_res++;

      check_val("e_req", bus.e_req, e_req_x);
      check_val("sum_ready", bus.sum_ready, ready_x);
      check_val("vec_en", bus.vec_en, xfer_x);
      check_val("res_valid", bus.res_valid, rv_x);
      check_val("res_last", bus.res_last, rl_x);
      check_val("busy", busy, busy_x);
      check_val("done", done, m_job && (cyc == m_done_cyc));
      check_val("cfg_err", cfg_err, cyc == m_cfg_cyc);
      check_val("credit_ovf", credit_ovf, m_ovf);
      check_val("vec_e_set", bus.vec_e_set, m_eset);
      check_val("vec_mode", bus.vec_mode, m_mode);
`ifdef QUAN_SCHED_STALL_CNT_EN
      check_val("stall_cnt", stall_cnt, m_stall);
`else
      check_val("stall_cnt", stall_cnt, 0);
`endif

      if (rv_x) begin
        void'(res_cyc_q.pop_front());
        void'(res_last_q.pop_front());
      end
      if (m_job && (m_ack_cyc >= 0) && (cyc > m_ack_cyc) && (m_issued < m_num) &&
          (m_credits == 0) && bus.sum_valid && (m_stall < 64'hFFFF_FFFF))
        m_stall++;
      if (xfer_x && !bus.credit_ret) m_credits--;
      else if (!xfer_x && bus.credit_ret) begin
        if (m_credits == CMAX) m_ovf = 1;
        else                   m_credits++;
      end
      if (xfer_x) begin
        lastv = (m_issued == m_num - 1);
        res_cyc_q.push_back(cyc + ML + 1);
        res_last_q.push_back(lastv);
        m_issued++;
        if (lastv) m_done_cyc = cyc + ML + 2;
      end
      if (e_req_x && bus.e_ack) begin
        m_ack_cyc = cyc;
        m_eset    = bus.e_set_in;
        m_mode    = m_mode_pend;
        if (m_num == 0) m_done_cyc = cyc + 2;
      end
      if (m_job && (cyc == m_done_cyc)) m_job = 0;
      if (bus.start && !m_job) begin
        if (bus.mode_cfg <= 4'd1) begin
          m_job = 1; m_start_cyc = cyc; m_ack_cyc = -1; m_done_cyc = -1;
          m_num = int'(bus.vec_num); m_issued = 0; m_mode_pend = bus.mode_cfg;
        end else begin
          m_cfg_cyc = cyc + 1;
        end
      end
      last_xfer = xfer_x;
    end
  end

  // Stimulus: all drives at posedge+1.
  int cr_mode = 0;   // 0 manual, 1 return after each transfer, 2 random
  bit sv_rand = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.e_ack = 1'b0;
      case (cr_mode)
        1:       bus.credit_ret = last_xfer;
        2:       bus.credit_ret = ($urandom_range(0, 2) == 0) && ((m_credits < CMAX) || ($urandom_range(0, 7) == 0));
        default: bus.credit_ret = 1'b0;
      endcase
      if (sv_rand) bus.sum_valid = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic start_job(input logic [3:0] mode, input int num, input logic [31:0] eset, input int ack_dly);
    bus.start = 1'b1; bus.mode_cfg = mode; bus.vec_num = 16'(num);
    tick();
    if (mode <= 4'd1) begin
      tick(ack_dly);
      bus.e_ack = 1'b1; bus.e_set_in = eset;
      tick();
    end
  endtask

  task automatic wait_job(input bit stray);
    int budget = 0;
    while (m_job && budget < 500) begin
      if (stray && ((m_done_cyc < 0) || (cyc < m_done_cyc)) && ($urandom_range(0, 9) == 0)) begin
        bus.start = 1'b1; bus.mode_cfg = 4'($urandom_range(0, 3)); bus.vec_num = 16'($urandom_range(0, 20));
      end
      tick();
      budget++;
    end
    check_val("job_end", m_job, 0);
  endtask

  task automatic refill();
    for (int i = 0; (i < 2 * CMAX) && (m_credits < CMAX); i++) begin
      bus.credit_ret = 1'b1;
      tick();
    end
  endtask

  int en0, res0, budget;

  initial begin
    bus.start = 0; bus.mode_cfg = 0; bus.vec_num = 0; bus.e_ack = 0; bus.e_set_in = 0;
    bus.sum_valid = 0; bus.credit_ret = 0;
    obs_en = 0; obs_res = 0;
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_val("idle_busy", busy, 0);
    check_val("idle_ready", bus.sum_ready, 0);

    // basic job, credits returned the cycle after each transfer
    cr_mode = 1; bus.sum_valid = 1'b1;
    en0 = obs_en; res0 = obs_res;
    start_job(4'd1, 4, 32'h1234_5678, 0);
    wait_job(0);
    check_val("basic_en_cnt", obs_en - en0, 4);
    check_val("basic_res_cnt", obs_res - res0, 4);
    check_val("basic_eset", bus.vec_e_set, 32'h1234_5678);
    check_val("basic_mode", bus.vec_mode, 1);

    // credit stall: 8 transfers, then two returns release the remaining two
    cr_mode = 0; tick(2);
    en0 = obs_en;
    start_job(4'd0, 10, 32'hCAFE_0001, 1);
    tick(14);
    check_val("stall_en_cnt", obs_en - en0, 8);
    check_val("stall_ready", bus.sum_ready, 0);
    bus.credit_ret = 1'b1; tick();
    bus.credit_ret = 1'b1; tick();
    wait_job(0);
    check_val("stall_total", obs_en - en0, 10);

    // overflow on a return with the pool already full
    refill(); tick();
    check_val("ovf_clear", credit_ovf, 0);
    bus.credit_ret = 1'b1; tick();
    check_val("ovf_set", credit_ovf, 1);

    // illegal mode and empty job
    bus.sum_valid = 1'b0;
    start_job(4'd2, 3, 32'h0, 0);
    check_val("cfg_err_pulse", cfg_err, 1);
    check_val("cfg_err_busy", busy, 0);
    tick(2);
    res0 = obs_res;
    start_job(4'd0, 0, 32'hBEEF_0000, 2);
    wait_job(0);
    check_val("empty_no_res", obs_res - res0, 0);

    // randomized jobs with random credits, valid gaps and stray starts
    cr_mode = 2; sv_rand = 1;
    for (int j = 0; j < 25; j++) begin
      start_job(4'($urandom_range(0, 3) == 0 ? $urandom_range(2, 15) : $urandom_range(0, 1)),
                int'($urandom_range(0, 12)), $urandom, int'($urandom_range(0, 3)));
      wait_job(1);
      tick(int'($urandom_range(0, 2)));
    end

    // reset mid-job with vectors in flight
    cr_mode = 0; sv_rand = 0; bus.sum_valid = 1'b1;
    refill(); tick();
    start_job(4'd1, 6, 32'h5A5A_A5A5, 0);
    budget = 0;
    while ((m_issued < 2) && (budget < 50)) begin tick(); budget++; end
    check_val("pre_reset_issued", m_issued >= 2, 1);
    res0 = obs_res;
    rst_n = 1'b0; bus.sum_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check_val("post_reset_res", obs_res - res0, 0);
    check_val("post_reset_busy", busy, 0);

    // fresh credits after reset: exactly CMAX transfers without returns
    bus.sum_valid = 1'b1;
    en0 = obs_en;
    start_job(4'd0, 9, 32'h0F0F_0F0F, 0);
    tick(15);
    check_val("post_reset_credits", obs_en - en0, CMAX);
    rst_n = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/quan_mult_e_sched.md
# quan_mult_E_sched

Sequencer for the quantization sum×E multiplier stage. It accepts a job command with mode, vector count and E_set request. It fetches the E scale set, then meters sum vectors from the systolic-array drain into the sum/E operand-register stage by driving its `en`. Under downstream credit flow control, it tracks the external multiplier pipeline so every product leaves with an aligned valid/last tag. It sits between the SA column drain, the E-scale buffer and the requant/output FIFO.

## Interface
- `MULT_LAT`, 3: pipeline stages of the external mult array (A/B inputs to P output).
- `CNT_WIDTH`, 16: width of the vector counters.
- `CREDIT_MAX`, 8: downstream FIFO slots; credit counter reset value.
- `E_SET_WIDTH`, 32: E scale set width (2 × 16-bit).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job command pulse; ignored unless FSM is in IDLE.
- `mode_cfg` in 4: 0 = 8×8 (1 channel), 1 = 1×8 (2 channels); other values are illegal.
- `vec_num` in CNT_WIDTH: number of sum vectors in the job.
- `e_req` out 1: E-set fetch request.
- `e_ack` in 1: E-set valid; `e_set_in` is sampled on the cycle `e_ack` is high.
- `e_set_in` in E_SET_WIDTH: E scale set.
- `sum_valid` in 1 / `sum_ready` out 1: sum-vector handshake; a transfer occurs when both are high.
- `vec_en` out 1: enable to the operand-register stage. Combinational: equals `sum_valid & sum_ready`.
- `vec_mode` out 4: registered mode for the operand stage.
- `vec_e_set` out E_SET_WIDTH: registered E set, held for the whole job.
- `credit_ret` in 1: the downstream FIFO freed one slot.
- `res_valid` out 1 / `res_last` out 1: aligned with mult P output; `res_last` marks the final vector of the job.
- `busy` out 1: FSM is not in IDLE.
- `done` out 1: one-cycle pulse at the end of a job.
- `cfg_err` out 1: one-cycle pulse when `start` arrives with an illegal mode.
- `credit_ovf` out 1: sticky; set when `credit_ret` arrives while credits already equal CREDIT_MAX.
- `stall_cnt` out 32: stall performance counter (see Configuration).

## Operation
- **FSM states:** IDLE, LOAD_E, RUN, DRAIN.
- **IDLE:**
  - `start` with `mode_cfg` ≤ 1: latch mode and `vec_num`, clear the issued counter, go to LOAD_E.
  - `start` with `mode_cfg` > 1: pulse `cfg_err` and stay in IDLE.
- **LOAD_E:** hold `e_req` high until `e_ack`. On `e_ack`, latch `vec_e_set` and `vec_mode`.
  - If `vec_num` = 0, go to DRAIN.
  - Otherwise go to RUN.
- **RUN:**
  - `sum_ready` = (credits > 0) & (issued < `vec_num`).
  - Each transfer: issued+1, credits−1, and a tag is pushed into a (1+MULT_LAT)-deep valid/last shift register.
  - `last` = (issued == `vec_num` − 1).
  - When the last transfer occurs, go to DRAIN.
- **DRAIN:** `sum_ready` = 0. When the shift register is empty, pulse `done` and return to IDLE.
- **Credits:**
  - A transfer and `credit_ret` in the same cycle leave the count unchanged.
  - `credit_ret` alone at CREDIT_MAX saturates the count and sets `credit_ovf`.
  - Credits persist across jobs; only reset restores them.
- **Value hold:** `vec_e_set` and `vec_mode` are stable from LOAD_E exit until the next LOAD_E. This keeps the operand stage consistent for in-flight vectors.
- **Reset (including mid-job):** all state clears. FSM goes to IDLE, issued = 0, credits = CREDIT_MAX, and the shift register is flushed, so no `res_valid` follows. Outputs reset to 0 except credits.

## Timing
- Transfer in cycle k: `vec_en` is high in cycle k, and the operand stage registers at the end of cycle k.
- `res_valid` is high in cycle k+1+MULT_LAT. Back-to-back transfers give back-to-back `res_valid`.
- `done` is asserted in the cycle after the final `res_valid`.
- `start` to first `e_req`: 1 cycle.
- `e_ack` to first possible `vec_en`: 1 cycle.
- `cfg_err` is asserted 1 cycle after the offending `start`.
- `vec_num` = 0: `done` is asserted 2 cycles after `e_ack`, and no `res_valid` is produced.

## Configuration
- **Macro `QUAN_SCHED_STALL_CNT_EN`.**
- **Defined:** `stall_cnt` increments in each RUN cycle that has `sum_valid` = 1, credits = 0 and issued < `vec_num`. It saturates at 2^32−1 and clears only on reset.
- **Undefined:** the counter logic is removed and `stall_cnt` is tied to 0.

## Test plan
- **Basic job:** MULT_LAT = 3, CREDIT_MAX = 8. `start`, mode 1, `vec_num` = 4, `e_ack` with `e_set_in` = 0x1234_5678, `sum_valid` held high, credits returned immediately.
  - Expect 4 consecutive `vec_en` cycles and `vec_e_set` = 0x12345678.
  - Expect `res_valid` 4 cycles after each `vec_en`, with `res_last` only on the 4th, and `done` 1 cycle after the 4th `res_valid`.
- **Credit stall:** `vec_num` = 10, no `credit_ret`. Expect exactly 8 transfers, then `sum_ready` = 0.
  - `credit_ret` ×2 → 2 more transfers, then `done`.
  - With the macro defined, `stall_cnt` equals the number of stalled `sum_valid` cycles.
- **Simultaneous and overflow credits:** a transfer and `credit_ret` in the same cycle leave credits unchanged; `credit_ret` at 8 credits sets `credit_ovf`.
- **Illegal and empty jobs:** mode 2 → `cfg_err` pulse, `busy` stays 0. `vec_num` = 0 → `done` pulse, no `res_valid`.
- **Reset and stray start:** deassert `rst_n` in RUN with 2 vectors in flight → no `res_valid` afterwards, credits = 8, `busy` = 0. `start` while `busy` → ignored.
